imem_loader: RTL and testbench

//  Boot-time program loader for the RV32I single-cycle core. Receives a byte stream
//  (length header, little-endian instruction words, checksum), writes words into

---
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the RV32I single-cycle core. A byte stream is
// framed as a 4-byte little-endian word count N, N little-endian instruction
// words, and a one-byte checksum (sum of the payload bytes mod 256). Words are
// written into instruction memory starting at word address 0. The core is held
// in reset until a frame completes with a matching checksum.
//
// Ports
//   clk_i           system clock, rising edge
//   reset_i         asynchronous, active-high reset
//   load_start_i    1-cycle pulse: abort any activity and begin a new load
//   rx_data_i       stream byte
//   rx_valid_i      rx_data_i valid
//   rx_ready_o      loader accepts a byte (transfer = rx_valid_i & rx_ready_o)
//   imem_we_o       instruction-memory write enable, one cycle per word
//   imem_addr_o     word address of the write
//   imem_wdata_o    instruction word to write
//   cpu_reset_o     core reset: 1 = held, 0 = running
//   busy_o          load in progress
//   done_o          last load succeeded (sticky until load_start_i / reset_i)
//   error_o         last load failed (sticky until load_start_i / reset_i)
//   words_loaded_o  words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_start_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  cpu_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StCheck,
        StDone,
        StErr
    } state_e;

    // Largest legal program, widened so the comparison cannot wrap.
    localparam logic [32:0] MaxWords = 33'(1) << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [31:0]           count_q, count_d;
    logic [ADDR_WIDTH:0]   index_q, index_d;
    logic [31:0]           word_sr_q, word_sr_d;
    logic [7:0]            sum_q, sum_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_reset_q, cpu_reset_d;

    logic                  xfer;
    logic [31:0]           len_shift;
    logic [ADDR_WIDTH:0]   index_inc;

    // Bytes arrive LSB first, so shifting in from the top leaves byte k at
    // bits 8k+7:8k once four bytes have been taken.
    assign len_shift = {rx_data_i, count_q[31:8]};
    assign index_inc = index_q + 1'b1;

    // ---------------------------------------------------------------------
    // Next-state and combinational outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        word_sr_d  = word_sr_q;
        sum_d      = sum_q;
        byte_cnt_d = byte_cnt_q;

        // load_start_i wins over the stream: no byte is consumed in that cycle.
        rx_ready_o = ((state_q == StLen) || (state_q == StData) || (state_q == StCheck))
                     && !load_start_i;
        xfer       = rx_ready_o && rx_valid_i;

        if (load_start_i) begin
            state_d    = StLen;
            count_d    = '0;
            index_d    = '0;
            word_sr_d  = '0;
            sum_d      = '0;
            byte_cnt_d = '0;
        end else begin
            unique case (state_q)
                StLen: begin
                    if (xfer) begin
                        count_d    = len_shift;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (len_shift == 32'd0) begin
                                state_d = StCheck;
                            end else if ({1'b0, len_shift} > MaxWords) begin
                                state_d = StErr;
                            end else begin
                                state_d = StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        word_sr_d  = {rx_data_i, word_sr_q[31:8]};
                        sum_d      = sum_q + rx_data_i;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_d = StWrite;
                        end
                    end
                end
                StWrite: begin
                    // byte_cnt_q has already wrapped to 0 for the next word.
                    index_d = index_inc;
                    if (32'(index_inc) == count_q) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
                StCheck: begin
                    if (xfer) begin
                        state_d = (rx_data_i == sum_q) ? StDone : StErr;
                    end
                end
                StIdle, StDone, StErr: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Status flags are registered copies of where the FSM is heading.
        done_d      = (state_d == StDone);
        error_d     = (state_d == StErr);
        cpu_reset_d = (state_d != StDone);
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            count_q     <= '0;
            index_q     <= '0;
            word_sr_q   <= '0;
            sum_q       <= '0;
            byte_cnt_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            index_q     <= index_d;
            word_sr_q   <= word_sr_d;
            sum_q       <= sum_d;
            byte_cnt_q  <= byte_cnt_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign imem_we_o      = (state_q == StWrite);
    assign imem_addr_o    = index_q[ADDR_WIDTH-1:0];
    assign imem_wdata_o   = word_sr_q;
    assign busy_o         = (state_q == StLen) || (state_q == StData) ||
                            (state_q == StWrite) || (state_q == StCheck);
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign cpu_reset_o    = cpu_reset_q;
    assign words_loaded_o = index_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader: a table of fixed frames with hand-known
// results, hand-written sequences for abort / reset / oversize cases, and
// randomized frames whose expected writes and status come from the framing
// rules (word list + byte sum) computed directly in the bench.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int unsigned AW = 10;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    typedef struct {
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  chk;
        int          pct;
        logic        exp_done;
        logic        exp_err;
        logic [AW:0] exp_wl;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int total = 0;
    int bad   = 0;
    int we_seen = 0;
    wr_t wq[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .load_start_i   (load_start),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .rx_ready_o     (rx_ready),
        .imem_we_o      (imem_we),
        .imem_addr_o    (imem_addr),
        .imem_wdata_o   (imem_wdata),
        .cpu_reset_o    (cpu_reset),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error),
        .words_loaded_o (words_loaded)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: record every write; the stream must be stalled during it.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq.push_back('{imem_addr, imem_wdata});
            we_seen++;
            check("write_rx_ready", {63'd0, rx_ready}, 64'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bq_t make_frame(input logic [31:0] n, input wq_t w, input logic [7:0] chk);
        bq_t b;
        for (int i = 0; i < 4; i++) b.push_back(n[8*i +: 8]);
        foreach (w[k]) for (int i = 0; i < 4; i++) b.push_back(w[k][8*i +: 8]);
        b.push_back(chk);
        return b;
    endfunction

    function automatic logic [7:0] sum8(input wq_t w);
        int s = 0;
        foreach (w[k]) for (int i = 0; i < 4; i++) s += int'(w[k][8*i +: 8]);
        return 8'(s);
    endfunction

    task automatic pulse_load();
        @(negedge clk);
        load_start = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'hFF;
        #1;
        check("load_start_rx_ready", {63'd0, rx_ready}, 64'd0);
        @(negedge clk);
        load_start = 1'b0;
        rx_valid   = 1'b0;
    endtask

    // Offer bytes in order; a byte is only advanced past once transferred.
    task automatic send(input bq_t bytes, input int pct);
        int idx = 0;
        int cyc = 0;
        bit v;
        while (idx < bytes.size() && cyc < 4000) begin
            @(negedge clk);
            v = ($urandom_range(99) < pct);
            rx_valid = v;
            rx_data  = v ? bytes[idx] : 8'($urandom);
            #1;
            if (v && rx_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check("bytes_sent", 64'(idx), 64'(bytes.size()));
    endtask

    task automatic run_frame(input string name, input logic [31:0] n, input wq_t w,
                             input logic [7:0] chk, input int pct, input bit do_load,
                             input logic exp_done, input logic exp_err, input logic [AW:0] exp_wl);
        if (do_load) pulse_load();
        wq.delete();
        send(make_frame(n, w, chk), pct);
        repeat (2) @(negedge clk);
        #1;
        check({name, "_done"}, {63'd0, done}, {63'd0, exp_done});
        check({name, "_error"}, {63'd0, error}, {63'd0, exp_err});
        check({name, "_cpu_reset"}, {63'd0, cpu_reset}, {63'd0, !exp_done});
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_rx_ready"}, {63'd0, rx_ready}, 64'd0);
        check({name, "_words_loaded"}, 64'(words_loaded), 64'(exp_wl));
        check({name, "_nwrites"}, 64'(wq.size()), 64'(w.size()));
        for (int i = 0; i < w.size() && i < wq.size(); i++) begin
            check({name, "_addr"}, 64'(wq[i].a), 64'(i));
            check({name, "_data"}, 64'(wq[i].d), 64'(w[i]));
        end
    endtask

    vec_t vecs[7];

    initial begin
        wq_t w;
        bq_t b;
        logic [31:0] n;
        logic        good;
        logic [7:0]  chk;

        vecs[0] = '{32'd2, 32'h00500093, 32'h00A00113, 8'h97, 100, 1'b1, 1'b0, 11'd2};
        vecs[1] = '{32'd2, 32'h00500093, 32'h00A00113, 8'h98, 100, 1'b0, 1'b1, 11'd2};
        vecs[2] = '{32'd0, 32'h0, 32'h0, 8'h00, 100, 1'b1, 1'b0, 11'd0};
        vecs[3] = '{32'd0, 32'h0, 32'h0, 8'h05, 100, 1'b0, 1'b1, 11'd0};
        vecs[4] = '{32'd1, 32'h01020304, 32'h0, 8'h0A, 100, 1'b1, 1'b0, 11'd1};
        vecs[5] = '{32'd2, 32'h00500093, 32'h00A00113, 8'h97, 40, 1'b1, 1'b0, 11'd2};
        vecs[6] = '{32'd1, 32'hFFFFFFFF, 32'h0, 8'hFC, 60, 1'b1, 1'b0, 11'd1};

        // Reset values
        #1 reset = 1'b1;
        #1;
        check("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("idle_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("idle_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("idle_no_writes", 64'(we_seen), 64'd0);
        rx_valid = 1'b0;

        // Table of fixed frames
        foreach (vecs[i]) begin
            w.delete();
            if (vecs[i].n >= 1) w.push_back(vecs[i].w0);
            if (vecs[i].n >= 2) w.push_back(vecs[i].w1);
            run_frame($sformatf("vec%0d", i), vecs[i].n, w, vecs[i].chk, vecs[i].pct, 1'b1,
                      vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_wl);
        end

        // Oversize header: N = 1025 fails right after the 4th byte
        pulse_load();
        wq.delete();
        b = '{8'h01, 8'h04, 8'h00, 8'h00};
        send(b, 100);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        #1;
        check("over_error", {63'd0, error}, 64'd1);
        check("over_done", {63'd0, done}, 64'd0);
        check("over_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("over_busy", {63'd0, busy}, 64'd0);
        check("over_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("over_nwrites", 64'(wq.size()), 64'd0);
        rx_valid = 1'b0;

        // Largest legal header: N = 1024 must enter the payload phase
        pulse_load();
        b = '{8'h00, 8'h04, 8'h00, 8'h00};
        send(b, 100);
        #1;
        check("max_busy", {63'd0, busy}, 64'd1);
        check("max_error", {63'd0, error}, 64'd0);
        check("max_rx_ready", {63'd0, rx_ready}, 64'd1);

        // Abort after 2 bytes of word 1: only word 0 is written
        pulse_load();
        wq.delete();
        b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send(b, 100);
        pulse_load();
        repeat (3) @(negedge clk);
        #1;
        check("abort_nwrites", 64'(wq.size()), 64'd1);
        if (wq.size() >= 1) check("abort_data", 64'(wq[0].d), 64'h44332211);
        check("abort_busy", {63'd0, busy}, 64'd1);
        check("abort_words", 64'(words_loaded), 64'd0);
        w = '{32'hDEADBEEF, 32'h12345678};
        run_frame("after_abort", 32'd2, w, sum8(w), 100, 1'b0, 1'b1, 1'b0, 11'd2);

        // Reset mid-DATA: outputs return to reset values without a clock edge
        pulse_load();
        b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        send(b, 100);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mrst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("mrst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("mrst_busy", {63'd0, busy}, 64'd0);
        check("mrst_done", {63'd0, done}, 64'd0);
        check("mrst_error", {63'd0, error}, 64'd0);
        check("mrst_we", {63'd0, imem_we}, 64'd0);
        check("mrst_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized frames against the framing rules
        for (int t = 0; t < 25; t++) begin
            n = 32'($urandom_range(1, 6));
            w.delete();
            for (int k = 0; k < int'(n); k++) w.push_back($urandom);
            good = 1'($urandom_range(1));
            chk  = sum8(w) ^ (good ? 8'h00 : 8'($urandom_range(1, 255)));
            run_frame($sformatf("rnd%0d", t), n, w, chk, $urandom_range(30, 100), 1'b1,
                      good, !good, n[AW:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
